// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Purpose  : TMDS control tokens, running-disparity type, popcount helper.
// Revision : 1.0 - initial release
// ============================================================================
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef logic signed [4:0] disparity_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_qm_stage.sv
`default_nettype none
// ============================================================================
// Module   : tmds_qm_stage
// Purpose  : Transition-minimising stage: XOR/XNOR chain plus q_m popcounts.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_i,
  input  logic [3:0] n1d_i,
  input  logic [1:0] c_i,
  input  logic       den_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1_o,
  output logic [3:0] n0_o,
  output logic [1:0] c_o,
  output logic       den_o
);

  logic       use_xnor;
  logic [8:0] qm_d;
  logic [3:0] n1_d;

  logic [8:0] qm_q;
  logic [3:0] n1_q;
  logic [3:0] n0_q;
  logic [1:0] c_q;
  logic       den_q;

  // XNOR is just XOR with an inverted term, so one chain serves both modes.
  always_comb begin
    use_xnor = (n1d_i > 4'd4) || ((n1d_i == 4'd4) && !d_i[0]);
    qm_d     = 9'd0;
    qm_d[0]  = d_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = qm_d[i-1] ^ d_i[i] ^ use_xnor;
    end
    qm_d[8] = ~use_xnor;
    n1_d    = popcount8(qm_d[7:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q  <= 9'd0;
      n1_q  <= 4'd0;
      n0_q  <= 4'd8;
      c_q   <= 2'b00;
      den_q <= 1'b0;
    end else begin
      qm_q  <= qm_d;
      n1_q  <= n1_d;
      n0_q  <= 4'd8 - n1_d;
      c_q   <= c_i;
      den_q <= den_i;
    end
  end

  assign qm_o  = qm_q;
  assign n1_o  = n1_q;
  assign n0_o  = n0_q;
  assign c_o   = c_q;
  assign den_o = den_q;

endmodule
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder
// Purpose  : 3-stage DVI TMDS channel encoder (8b data / 2b control -> 10b).
//            Optional macro TMDS_ENCODER_DISPARITY_OUT_EN exposes the running
//            disparity as an extra output.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] c,
  input  logic [7:0] d,
  input  logic       den,
  output logic [9:0] q
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
  ,
  output disparity_t disparity
`endif
);

  logic [1:0] c_s1_q;
  logic [7:0] d_s1_q;
  logic       den_s1_q;
  logic [3:0] n1d_s1_q;

  logic [8:0] qm_s2;
  logic [3:0] n1_s2;
  logic [3:0] n0_s2;
  logic [1:0] c_s2;
  logic       den_s2;

  logic [9:0] q_d;
  logic [9:0] q_q;
  disparity_t cnt_d;
  disparity_t cnt_q;
  disparity_t bal;
  disparity_t delta;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1_q   <= 2'b00;
      d_s1_q   <= 8'd0;
      den_s1_q <= 1'b0;
      n1d_s1_q <= 4'd0;
    end else begin
      c_s1_q   <= c;
      d_s1_q   <= d;
      den_s1_q <= den;
      n1d_s1_q <= popcount8(d);
    end
  end

  tmds_qm_stage u_qm_stage (
    .clk   (clk),
    .rst   (rst),
    .d_i   (d_s1_q),
    .n1d_i (n1d_s1_q),
    .c_i   (c_s1_q),
    .den_i (den_s1_q),
    .qm_o  (qm_s2),
    .n1_o  (n1_s2),
    .n0_o  (n0_s2),
    .c_o   (c_s2),
    .den_o (den_s2)
  );

  // In the middle branch both cnt and bal are non-zero, so sign bits decide.
  always_comb begin
    bal   = $signed({1'b0, n1_s2}) - $signed({1'b0, n0_s2});
    delta = 5'sd0;
    q_d   = CTRL_TOKEN_00;
    cnt_d = 5'sd0;
    if (!den_s2) begin
      unique case (c_s2)
        2'b00:   q_d = CTRL_TOKEN_00;
        2'b01:   q_d = CTRL_TOKEN_01;
        2'b10:   q_d = CTRL_TOKEN_10;
        default: q_d = CTRL_TOKEN_11;
      endcase
    end else begin
      if ((cnt_q == 5'sd0) || (bal == 5'sd0)) begin
        q_d   = {~qm_s2[8], qm_s2[8], qm_s2[8] ? qm_s2[7:0] : ~qm_s2[7:0]};
        delta = qm_s2[8] ? bal : -bal;
      end else if (cnt_q[4] == bal[4]) begin
        q_d   = {1'b1, qm_s2[8], ~qm_s2[7:0]};
        delta = (qm_s2[8] ? 5'sd2 : 5'sd0) - bal;
      end else begin
        q_d   = {1'b0, qm_s2[8], qm_s2[7:0]};
        delta = bal - (qm_s2[8] ? 5'sd0 : 5'sd2);
      end
      cnt_d = cnt_q + delta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= CTRL_TOKEN_00;
      cnt_q <= 5'sd0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
  assign disparity = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_encoder
// Purpose  : Scoreboard bench for tmds_encoder against a DVI 1.0 reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_encoder;

  logic       clk;
  logic       rst;
  logic [1:0] c;
  logic [7:0] d;
  logic       den;
  logic [9:0] q;
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
  logic signed [4:0] disparity;
`endif

  tmds_encoder dut (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .d   (d),
    .den (den),
    .q   (q)
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
    ,
    .disparity (disparity)
`endif
  );

  typedef struct {
    int         due;
    logic [9:0] q;
    int         cnt;
  } exp_t;

  exp_t       sb[$];
  int         edges  = 0;
  int         checks = 0;
  int         errors = 0;
  int         m_cnt  = 0;
  logic [9:0] tok [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  // Reference: invert-or-not decision from signs, cnt from the emitted word's own balance.
  task automatic model_step(input logic de, input logic [1:0] cc, input logic [7:0] dd,
                            output logic [9:0] qv);
    int         ones, ones_qm, bal, pop;
    logic       xn, inv;
    logic [8:0] qm;
    if (!de) begin
      qv    = tok[cc];
      m_cnt = 0;
    end else begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(dd[i]);
      xn    = (ones > 4) || (ones == 4 && dd[0] == 1'b0);
      qm    = '0;
      qm[0] = dd[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
      qm[8] = ~xn;
      ones_qm = 0;
      for (int i = 0; i < 8; i++) ones_qm += int'(qm[i]);
      bal = 2 * ones_qm - 8;
      if (m_cnt == 0 || bal == 0) inv = ~qm[8];
      else                        inv = ((m_cnt > 0) == (bal > 0));
      qv  = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
      pop = 0;
      for (int i = 0; i < 10; i++) pop += int'(qv[i]);
      m_cnt = m_cnt + 2 * pop - 10;
    end
  endtask

  // use_exp: push the supplied constant instead of the model result.
  task automatic issue(input logic r, input logic de, input logic [1:0] cc,
                       input logic [7:0] dd, input logic use_exp, input logic [9:0] expq);
    int         n;
    logic [9:0] qv;
    exp_t       e;
    @(negedge clk);
    n   = edges;
    rst = r; den = de; c = cc; d = dd;
    if (r) begin
      while (sb.size() > 0 && sb[$].due >= n) void'(sb.pop_back());
      m_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        e = '{n + k, tok[0], 0};
        sb.push_back(e);
      end
    end else begin
      model_step(de, cc, dd, qv);
      e = '{n + 2, use_exp ? expq : qv, m_cnt};
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t x;
    int   e;
    forever begin
      @(posedge clk);
      #1;
      e = edges - 1;
      while (sb.size() > 0 && sb[0].due <= e) begin
        x = sb.pop_front();
        checks++;
        if (x.due != e || q !== x.q) begin
          errors++;
          $display("FAIL q_char due=%0d edge=%0d actual=%b expected=%b", x.due, e, q, x.q);
        end
        checks++;
        if (x.cnt > 10 || x.cnt < -10 || (x.cnt % 2) != 0) begin
          errors++;
          $display("FAIL cnt_bound edge=%0d actual=%0d expected=even,|cnt|<=10", e, x.cnt);
        end
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
        checks++;
        if (int'(disparity) != x.cnt) begin
          errors++;
          $display("FAIL disparity edge=%0d actual=%0d expected=%0d", e, disparity, x.cnt);
        end
`endif
      end
    end
  end

  initial begin
    logic [31:0] rv;
    tok[0] = 10'b1101010100;
    tok[1] = 10'b0010101011;
    tok[2] = 10'b0101010100;
    tok[3] = 10'b1010101011;
    rst = 1'b1; den = 1'b0; c = 2'b00; d = 8'h00;

    issue(1, 0, 2'b00, 8'h00, 0, '0);
    issue(1, 0, 2'b00, 8'h00, 0, '0);
    issue(0, 0, 2'b00, 8'h00, 1, 10'b1101010100);
    issue(0, 0, 2'b01, 8'h00, 1, 10'b0010101011);
    issue(0, 0, 2'b10, 8'h00, 1, 10'b0101010100);
    issue(0, 0, 2'b11, 8'h00, 1, 10'b1010101011);
    issue(0, 1, 2'b00, 8'h00, 1, 10'b0100000000);
    issue(0, 1, 2'b00, 8'h00, 1, 10'b1111111111);
    issue(0, 0, 2'b00, 8'h00, 1, 10'b1101010100);
    issue(0, 1, 2'b00, 8'hFF, 1, 10'b1000000000);
    issue(0, 0, 2'b00, 8'h00, 1, 10'b1101010100);
    issue(0, 1, 2'b00, 8'h00, 1, 10'b0100000000);
    issue(0, 0, 2'b00, 8'h00, 1, 10'b1101010100);
    issue(0, 1, 2'b00, 8'h00, 1, 10'b0100000000);

    for (int i = 0; i < 1000; i++) begin
      rv = $urandom;
      issue(rv[31:25] == 7'd0, rv[24:23] != 2'b00, rv[1:0], rv[9:2], 0, '0);
    end

    for (int i = 0; i < 5; i++) begin
      rv = $urandom;
      issue(0, 1, 2'b00, rv[7:0], 0, '0);
    end
    issue(1, 1, 2'b00, 8'h55, 0, '0);
    issue(0, 1, 2'b00, 8'h00, 1, 10'b0100000000);
    issue(0, 1, 2'b00, 8'h00, 1, 10'b1111111111);
    issue(0, 0, 2'b00, 8'h00, 0, '0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
